// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: turns MODE/SEL/INC buttons into the run/set state,
// a field cursor, one-cycle increment strobes, hold-to-repeat, timeout and blink.
module clock_set_ctrl #(
  parameter int HOLD_TICKS = 5,
  parameter int TIMEOUT_S  = 30,
  parameter int BLINK_HALF = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_MODE,
  input  logic       BTN_SEL,
  input  logic       BTN_INC,
  input  logic       TICK_1HZ,
  input  logic       TICK_10HZ,
  output logic [1:0] SET_CURRENT_STATE,
  output logic [5:0] INC_SEL,
  output logic [2:0] FIELD_SEL,
  output logic       BLINK
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_S + 1);
  localparam int BLK_W  = $clog2(BLINK_HALF + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLD_TICKS);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_S - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLINK_HALF - 1);
  localparam logic [2:0]        FIELD_YEAR = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN = 2'b01,
    ST_SET = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        hist_q, hist_d;
  logic              armed_q, armed_d;
  logic [2:0]        field_q, field_d;
  logic              inc_req_p0_q, inc_req_p0_d;
  logic [2:0]        inc_fld_p0_q, inc_fld_p0_d;
  logic [5:0]        inc_sel_p1_q, inc_sel_p1_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              blink_q, blink_d;

  logic rise_mode, rise_sel, rise_inc;
  logic repeat_tick, inc_evt, activity, in_set;

  // armed_q masks the first cycle after reset so a button held through reset gives no edge
  assign rise_mode   = armed_q & BTN_MODE & ~hist_q[2];
  assign rise_sel    = armed_q & BTN_SEL  & ~hist_q[1];
  assign rise_inc    = armed_q & BTN_INC  & ~hist_q[0];
  assign in_set      = (state_q == ST_SET);
  assign repeat_tick = BTN_INC & TICK_10HZ & (hold_q == HOLD_MAX);
  assign inc_evt     = rise_inc | repeat_tick;
  assign activity    = rise_mode | rise_sel | rise_inc | BTN_INC;

  always_comb begin
    hist_d       = {BTN_MODE, BTN_SEL, BTN_INC};
    armed_d      = 1'b1;
    state_d      = state_q;
    field_d      = field_q;
    inc_req_p0_d = 1'b0;
    inc_fld_p0_d = field_q;
    hold_d       = hold_q;
    tmo_d        = tmo_q;
    blk_cnt_d    = blk_cnt_q;
    blink_d      = blink_q;

    if (!in_set) begin
      hold_d    = '0;
      tmo_d     = '0;
      blk_cnt_d = '0;
      blink_d   = 1'b1;
      if (rise_mode) begin
        state_d = ST_SET;
        field_d = FIELD_YEAR;
      end
    end else begin
      if (!BTN_INC || rise_inc) begin
        hold_d = '0;
      end else if (TICK_10HZ && (hold_q != HOLD_MAX)) begin
        hold_d = hold_q + HOLD_W'(1);
      end

      if (rise_sel || rise_inc || BTN_INC) begin
        blk_cnt_d = '0;
        blink_d   = 1'b1;
      end else if (TICK_10HZ) begin
        if (blk_cnt_q >= BLK_LAST) begin
          blk_cnt_d = '0;
          blink_d   = ~blink_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BLK_W'(1);
        end
      end

      if (activity) begin
        tmo_d = '0;
      end else if (TICK_1HZ) begin
        if (tmo_q >= TMO_LAST) begin
          tmo_d   = '0;
          state_d = ST_RUN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      // MODE outranks SEL outranks INC; losers in the same cycle are dropped
      if (rise_mode) begin
        state_d = ST_RUN;
      end else if (rise_sel) begin
        field_d = (field_q == 3'd0) ? FIELD_YEAR : field_q - 3'd1;
      end else if (inc_evt) begin
        inc_req_p0_d = 1'b1;
        inc_fld_p0_d = field_q;
      end

      if (state_d == ST_RUN) begin
        hold_d       = '0;
        tmo_d        = '0;
        blk_cnt_d    = '0;
        blink_d      = 1'b1;
        inc_req_p0_d = 1'b0;
      end
    end

    // strobe stage: a pending request is dropped if this edge leaves SET
    inc_sel_p1_d = '0;
    if (inc_req_p0_q && (state_d == ST_SET)) begin
      inc_sel_p1_d = 6'd1 << inc_fld_p0_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      hist_q       <= '0;
      armed_q      <= 1'b0;
      field_q      <= FIELD_YEAR;
      inc_req_p0_q <= 1'b0;
      inc_fld_p0_q <= '0;
      inc_sel_p1_q <= '0;
      hold_q       <= '0;
      tmo_q        <= '0;
      blk_cnt_q    <= '0;
      blink_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      armed_q      <= armed_d;
      field_q      <= field_d;
      inc_req_p0_q <= inc_req_p0_d;
      inc_fld_p0_q <= inc_fld_p0_d;
      inc_sel_p1_q <= inc_sel_p1_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      blk_cnt_q    <= blk_cnt_d;
      blink_q      <= blink_d;
    end
  end

  assign SET_CURRENT_STATE = state_q;
  assign INC_SEL           = inc_sel_p1_q;
  assign FIELD_SEL         = field_q;
  assign BLINK             = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus randomized button/tick
// traffic, every cycle compared against an event-level reference model.
module tb_clock_set_ctrl;

  localparam int HOLD = 5;
  localparam int TMO  = 30;
  localparam int BH   = 5;

  logic       CLK, RESET;
  logic       BTN_MODE, BTN_SEL, BTN_INC, TICK_1HZ, TICK_10HZ;
  logic [1:0] SET_CURRENT_STATE;
  logic [5:0] INC_SEL;
  logic [2:0] FIELD_SEL;
  logic       BLINK;

  clock_set_ctrl #(.HOLD_TICKS(HOLD), .TIMEOUT_S(TMO), .BLINK_HALF(BH)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTN_MODE(BTN_MODE), .BTN_SEL(BTN_SEL), .BTN_INC(BTN_INC),
    .TICK_1HZ(TICK_1HZ), .TICK_10HZ(TICK_10HZ),
    .SET_CURRENT_STATE(SET_CURRENT_STATE), .INC_SEL(INC_SEL),
    .FIELD_SEL(FIELD_SEL), .BLINK(BLINK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  bit m_set, m_armed, h_m, h_s, h_i;
  int m_field, m_hold, m_idle, m_bcnt, m_blink, m_pend, m_inc;

  task automatic model_update();
    bit rm, rs, ri, rep, was_set;
    int new_pend;
    if (RESET) begin
      m_set = 0; m_field = 5; m_hold = 0; m_idle = 0; m_bcnt = 0; m_blink = 1;
      m_pend = -1; m_inc = 0; h_m = 0; h_s = 0; h_i = 0; m_armed = 0;
      return;
    end
    rm = m_armed && BTN_MODE && !h_m;
    rs = m_armed && BTN_SEL  && !h_s;
    ri = m_armed && BTN_INC  && !h_i;
    h_m = BTN_MODE; h_s = BTN_SEL; h_i = BTN_INC; m_armed = 1;
    was_set  = m_set;
    rep      = was_set && BTN_INC && TICK_10HZ && (m_hold == HOLD);
    new_pend = -1;
    if (!was_set) begin
      if (rm) begin m_set = 1; m_field = 5; end
    end else begin
      if (rm)              m_set = 0;
      else if (rs)         m_field = (m_field + 5) % 6;
      else if (ri || rep)  new_pend = m_field;
      if (rm || rs || ri || BTN_INC) m_idle = 0;
      else if (TICK_1HZ) begin
        m_idle++;
        if (m_idle == TMO) m_set = 0;
      end
      if (!BTN_INC || ri) m_hold = 0;
      else if (TICK_10HZ && m_hold < HOLD) m_hold++;
      if (rs || ri || BTN_INC) begin m_bcnt = 0; m_blink = 1; end
      else if (TICK_10HZ) begin
        m_bcnt++;
        if (m_bcnt == BH) begin m_bcnt = 0; m_blink = 1 - m_blink; end
      end
    end
    if (!m_set) begin
      m_hold = 0; m_idle = 0; m_bcnt = 0; m_blink = 1; new_pend = -1;
    end
    m_inc  = (m_pend >= 0 && m_set) ? (1 << m_pend) : 0;
    m_pend = new_pend;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_update();
    #1;
    chk("state",   SET_CURRENT_STATE, m_set ? 2 : 1);
    chk("field",   FIELD_SEL, m_field);
    chk("inc_sel", INC_SEL, m_inc);
    chk("blink",   BLINK, m_blink);
  endtask

  task automatic idle(input int n);
    BTN_MODE = 0; BTN_SEL = 0; BTN_INC = 0; TICK_1HZ = 0; TICK_10HZ = 0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic press_mode();
    BTN_MODE = 1; cyc();
    BTN_MODE = 0; cyc();
  endtask

  int strobes;
  int fld_before;
  int thr;
  int len;

  initial begin
    RESET = 1; BTN_MODE = 0; BTN_SEL = 0; BTN_INC = 0; TICK_1HZ = 0; TICK_10HZ = 0;
    cyc(); cyc();
    RESET = 0;

    // 1: reset values after idle
    idle(10);
    chk("t1_state", SET_CURRENT_STATE, 1);
    chk("t1_field", FIELD_SEL, 5);
    chk("t1_inc",   INC_SEL, 0);
    chk("t1_blink", BLINK, 1);

    // SEL/INC ignored in RUN
    BTN_SEL = 1; BTN_INC = 1; cyc(); cyc(); cyc();
    chk("run_ignore_field", FIELD_SEL, 5);
    BTN_SEL = 0; BTN_INC = 0; cyc();

    // 2: enter SET, INC held 3 cycles gives one YEAR strobe two cycles later
    press_mode();
    chk("t2_state", SET_CURRENT_STATE, 2);
    BTN_INC = 1; cyc();
    chk("t2_lat1", INC_SEL, 0);
    cyc();
    chk("t2_lat2", INC_SEL, 6'b100000);
    cyc();
    chk("t2_lat3", INC_SEL, 0);
    BTN_INC = 0; cyc(); cyc();

    // 3: cursor walk and SEC strobe
    for (int k = 0; k < 6; k++) begin
      BTN_SEL = 1; cyc();
      chk("t3_field", FIELD_SEL, (k == 5) ? 5 : 4 - k);
      BTN_SEL = 0; cyc();
      if (k == 4) begin
        BTN_INC = 1; cyc(); cyc();
        chk("t3_sec_strobe", INC_SEL, 6'b000001);
        BTN_INC = 0; cyc();
      end
    end

    // 4: hold-to-repeat over 12 ticks
    strobes = 0;
    BTN_INC = 1; cyc();
    if (INC_SEL != 0) strobes++;
    for (int k = 0; k < 12; k++) begin
      TICK_10HZ = 1; cyc(); if (INC_SEL != 0) strobes++;
      TICK_10HZ = 0; cyc(); if (INC_SEL != 0) strobes++;
      cyc(); if (INC_SEL != 0) strobes++;
    end
    BTN_INC = 0;
    for (int k = 0; k < 4; k++) begin cyc(); if (INC_SEL != 0) strobes++; end
    chk("t4_strobes", strobes, 8);
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      TICK_10HZ = 1; cyc(); if (INC_SEL != 0) strobes++;
      TICK_10HZ = 0; cyc(); if (INC_SEL != 0) strobes++;
    end
    chk("t4_after_release", strobes, 0);
    // re-press holding only 4 ticks: a cleared hold counter gives no repeat
    BTN_INC = 1; cyc();
    for (int k = 0; k < 4; k++) begin
      TICK_10HZ = 1; cyc(); if (INC_SEL != 0) strobes++;
      TICK_10HZ = 0; cyc(); if (INC_SEL != 0) strobes++;
    end
    BTN_INC = 0; cyc(); cyc();
    chk("t4_hold_cleared", strobes, 1);

    // 5: simultaneous rises -> RUN only
    fld_before = FIELD_SEL;
    BTN_MODE = 1; BTN_SEL = 1; BTN_INC = 1; cyc();
    chk("t5_state", SET_CURRENT_STATE, 1);
    chk("t5_field", FIELD_SEL, fld_before);
    chk("t5_inc0",  INC_SEL, 0);
    cyc();
    chk("t5_inc1",  INC_SEL, 0);
    idle(2);

    // 6: inactivity timeout, then restart by an INC press at tick 20
    press_mode();
    for (int k = 1; k <= 30; k++) begin
      TICK_1HZ = 1; cyc();
      if (k == 29) chk("t6_still_set", SET_CURRENT_STATE, 2);
      if (k == 30) chk("t6_timeout", SET_CURRENT_STATE, 1);
      TICK_1HZ = 0; cyc();
    end
    press_mode();
    for (int k = 1; k <= 20; k++) begin TICK_1HZ = 1; cyc(); TICK_1HZ = 0; cyc(); end
    BTN_INC = 1; cyc(); BTN_INC = 0; cyc(); cyc();
    for (int k = 1; k <= 30; k++) begin
      TICK_1HZ = 1; cyc();
      if (k == 29) chk("t6b_still_set", SET_CURRENT_STATE, 2);
      if (k == 30) chk("t6b_timeout", SET_CURRENT_STATE, 1);
      TICK_1HZ = 0; cyc();
    end

    // button held through reset release gives no edge
    RESET = 1; BTN_MODE = 1; cyc(); cyc();
    RESET = 0; cyc(); cyc(); cyc();
    chk("held_reset_no_edge", SET_CURRENT_STATE, 1);
    idle(2);

    // randomized traffic
    for (int seg = 0; seg < 30; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        RESET = 1;
        BTN_MODE = 1'($urandom_range(0, 1));
        BTN_INC  = 1'($urandom_range(0, 1));
        cyc(); cyc();
        RESET = 0;
      end
      case ($urandom_range(0, 2))
        0:       thr = 0;
        1:       thr = 25;
        default: thr = 125;
      endcase
      len = $urandom_range(40, 200);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 999) < thr) BTN_MODE = ~BTN_MODE;
        if ($urandom_range(0, 999) < thr) BTN_SEL  = ~BTN_SEL;
        if ($urandom_range(0, 999) < thr) BTN_INC  = ~BTN_INC;
        TICK_10HZ = ($urandom_range(0, 2) == 0);
        TICK_1HZ  = ($urandom_range(0, 3) == 0);
        cyc();
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
